// File: rtl/ffnn_weight_bank_pkg.sv
// Shared constants for the FFNN layer weight bank: register offsets, bit positions,
// commit FSM state type and the index-width helper.
package ffnn_weight_pkg;

    localparam int WEIGHT_W_DEFAULT = 17;
    localparam int COMMIT_CNT_W     = 8;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] IRQ_EN_OFS = 2'd2;

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_RD_ACTIVE_BIT = 1;
    localparam int CTRL_ABORT_BIT     = 2;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_IRQ_BIT     = 1;
    localparam int STATUS_VALID_BIT   = 2;
    localparam int STATUS_CNT_LSB     = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    // A single-weight bank still needs one index bit on the bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ffnn_weight_bank_if.sv
// Avalon-MM slave bus between the layer controller and the weight bank.
interface ffnn_weight_bank_if #(
    parameter int NUM_WEIGHTS = 8
);
    import ffnn_weight_pkg::*;

    localparam int IDX_W = idx_width(NUM_WEIGHTS);

    logic [IDX_W:0] address;
    logic           chipselect;
    logic           write_n;
    logic [31:0]    writedata;
    logic [31:0]    readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/ffnn_weight_bank_ctrl.sv
// Commit sequencer for the weight bank: pending request, copy strobe, commit counter
// and, with FFNN_WEIGHT_BANK_IRQ_EN defined, the interrupt flag/enable.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no commit requested
// ST_PENDING | commit requested, copy fires on first edge with busy low
module ffnn_weight_bank_ctrl
    import ffnn_weight_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    layer_busy_i,
    input  logic                    ctrl_wr_i,
    input  logic                    commit_bit_i,
    input  logic                    abort_bit_i,
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
    input  logic                    status_wr_i,
    input  logic                    irq_clr_bit_i,
    input  logic                    irq_en_wr_i,
    input  logic                    irq_en_bit_i,
    output logic                    irq_o,
`endif
    output logic                    copy_o,
    output logic                    pending_o,
    output logic                    weights_valid_o,
    output logic                    commit_done_o,
    output logic [COMMIT_CNT_W-1:0] commit_count_o,
    output logic                    irq_flag_o,
    output logic                    irq_en_o
);

    commit_state_t             state_q;
    logic                      weights_valid_q;
    logic                      commit_done_q;
    logic [COMMIT_CNT_W-1:0]   commit_count_q;
    logic                      commit_req;
    logic                      abort_req;

    assign commit_req = ctrl_wr_i & commit_bit_i & ~abort_bit_i;
    assign abort_req  = ctrl_wr_i & abort_bit_i;
    assign copy_o     = (state_q == ST_PENDING) & ~layer_busy_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            weights_valid_q <= 1'b0;
            commit_done_q   <= 1'b0;
            commit_count_q  <= '0;
        end else begin
            commit_done_q <= copy_o;
            if (copy_o) begin
                weights_valid_q <= 1'b1;
                commit_count_q  <= commit_count_q + COMMIT_CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (commit_req) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    // A COMMIT landing on the copy edge queues a second copy.
                    if (copy_o)         state_q <= commit_req ? ST_PENDING : ST_IDLE;
                    else if (abort_req) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pending_o       = (state_q == ST_PENDING);
    assign weights_valid_o = weights_valid_q;
    assign commit_done_o   = commit_done_q;
    assign commit_count_o  = commit_count_q;

`ifdef FFNN_WEIGHT_BANK_IRQ_EN
    logic irq_flag_q, irq_flag_d;
    logic irq_en_q, irq_en_d;
    logic irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (irq_en_wr_i) irq_en_d = irq_en_bit_i;
        irq_flag_d = irq_flag_q;
        if (status_wr_i && irq_clr_bit_i) irq_flag_d = 1'b0;
        if (copy_o) irq_flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_flag_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_flag_q <= irq_flag_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_flag_d & irq_en_d;
        end
    end

    assign irq_flag_o = irq_flag_q;
    assign irq_en_o   = irq_en_q;
    assign irq_o      = irq_q;
`else
    assign irq_flag_o = 1'b0;
    assign irq_en_o   = 1'b0;
`endif

endmodule

// File: rtl/ffnn_weight_bank.sv
// Double-buffered FFNN layer weight store on an Avalon-MM slave: shadow/active banks,
// address decode and read mux. Define FFNN_WEIGHT_BANK_IRQ_EN to add the irq output.
module ffnn_weight_bank
    import ffnn_weight_pkg::*;
#(
    parameter int WEIGHT_W    = WEIGHT_W_DEFAULT,
    parameter int NUM_WEIGHTS = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    ffnn_weight_bank_if.slave               bus,
    input  logic                            layer_busy,
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
    output logic                            irq,
`endif
    output logic [NUM_WEIGHTS*WEIGHT_W-1:0] weights_out,
    output logic                            weights_valid,
    output logic                            commit_done
);

    localparam int             IDX_W         = idx_width(NUM_WEIGHTS);
    localparam logic [IDX_W:0] NUM_WEIGHTS_L = (IDX_W+1)'(NUM_WEIGHTS);

    logic [WEIGHT_W-1:0]     shadow_q [NUM_WEIGHTS];
    logic [WEIGHT_W-1:0]     active_q [NUM_WEIGHTS];
    logic                    rd_active_q;

    logic                    is_ctrl;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              ofs;
    logic                    idx_ok;
    logic                    wr_en;
    logic                    wr_weight;
    logic                    wr_ctrl;

    logic                    copy;
    logic                    pending;
    logic [COMMIT_CNT_W-1:0] commit_count;
    logic                    irq_flag;
    logic                    irq_en;

    logic signed [WEIGHT_W-1:0] rd_weight;
    logic [31:0]                status;
    logic [31:0]                readdata_d;
    logic                       unused_wdata;

    assign is_ctrl   = bus.address[IDX_W];
    assign idx       = bus.address[IDX_W-1:0];
    assign ofs       = 2'(bus.address[IDX_W-1:0]);
    assign idx_ok    = {1'b0, idx} < NUM_WEIGHTS_L;
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wr_weight = wr_en & ~is_ctrl & idx_ok;
    assign wr_ctrl   = wr_en & is_ctrl & (ofs == CTRL_OFS);

    assign unused_wdata = ^bus.writedata;

`ifdef FFNN_WEIGHT_BANK_IRQ_EN
    logic wr_status;
    logic wr_irq_en;

    assign wr_status = wr_en & is_ctrl & (ofs == STATUS_OFS);
    assign wr_irq_en = wr_en & is_ctrl & (ofs == IRQ_EN_OFS);
`endif

    ffnn_weight_bank_ctrl u_ctrl (
        .clk             (clk),
        .reset_n         (reset_n),
        .layer_busy_i    (layer_busy),
        .ctrl_wr_i       (wr_ctrl),
        .commit_bit_i    (bus.writedata[CTRL_COMMIT_BIT]),
        .abort_bit_i     (bus.writedata[CTRL_ABORT_BIT]),
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
        .status_wr_i     (wr_status),
        .irq_clr_bit_i   (bus.writedata[STATUS_IRQ_BIT]),
        .irq_en_wr_i     (wr_irq_en),
        .irq_en_bit_i    (bus.writedata[0]),
        .irq_o           (irq),
`endif
        .copy_o          (copy),
        .pending_o       (pending),
        .weights_valid_o (weights_valid),
        .commit_done_o   (commit_done),
        .commit_count_o  (commit_count),
        .irq_flag_o      (irq_flag),
        .irq_en_o        (irq_en)
    );

    // Non-blocking copy reads the pre-write shadow when a write shares the copy edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            rd_active_q <= 1'b0;
        end else begin
            if (copy) begin
                for (int i = 0; i < NUM_WEIGHTS; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_weight) shadow_q[idx] <= bus.writedata[WEIGHT_W-1:0];
            if (wr_ctrl)   rd_active_q   <= bus.writedata[CTRL_RD_ACTIVE_BIT];
        end
    end

    for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_out
        assign weights_out[g*WEIGHT_W +: WEIGHT_W] = active_q[g];
    end

    always_comb begin
        status                                      = '0;
        status[STATUS_PENDING_BIT]                  = pending;
        status[STATUS_IRQ_BIT]                      = irq_flag;
        status[STATUS_VALID_BIT]                    = weights_valid;
        status[STATUS_CNT_LSB +: COMMIT_CNT_W]      = commit_count;
    end

    always_comb begin
        readdata_d = '0;
        rd_weight  = '0;
        if (!is_ctrl) begin
            if (idx_ok) begin
                rd_weight  = rd_active_q ? active_q[idx] : shadow_q[idx];
                readdata_d = 32'(rd_weight);
            end
        end else begin
            case (ofs)
                CTRL_OFS:   readdata_d[CTRL_RD_ACTIVE_BIT] = rd_active_q;
                STATUS_OFS: readdata_d = status;
                IRQ_EN_OFS: readdata_d[0] = irq_en;
                default:    readdata_d = '0;
            endcase
        end
    end

    assign bus.readdata = readdata_d;

endmodule

// File: tb/tb_ffnn_weight_bank.sv
// Scoreboard bench for ffnn_weight_bank: read and commit expectations are queued by the
// stimulus and popped by a monitor when the DUT presents a read or a commit_done pulse.
module tb_ffnn_weight_bank;
    import ffnn_weight_pkg::*;

    localparam int WW = 17;
    localparam int NW = 6;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_STATUS = 4'h9;
    localparam logic [3:0] A_IRQEN  = 4'hA;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic layer_busy = 1'b0;
    logic [NW*WW-1:0] weights_out;
    logic weights_valid;
    logic commit_done;
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
    logic irq;
`endif

    ffnn_weight_bank_if #(.NUM_WEIGHTS(NW)) bus ();

    ffnn_weight_bank #(.WEIGHT_W(WW), .NUM_WEIGHTS(NW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .layer_busy    (layer_busy),
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
        .irq           (irq),
`endif
        .weights_out   (weights_out),
        .weights_valid (weights_valid),
        .commit_done   (commit_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    int               n_checks = 0;
    int               n_fail   = 0;
    rd_exp_t          rd_q[$];
    logic [NW*WW-1:0] cq[$];
    logic             rd_req = 1'b0;
    logic [WW-1:0]    shadow_m [NW];
    logic [WW-1:0]    active_m [NW];
    logic [NW*WW-1:0] snap;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NW*WW-1:0] pack_active();
        logic [NW*WW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*WW +: WW] = active_m[i];
        return v;
    endfunction

    task automatic model_copy();
        for (int i = 0; i < NW; i++) active_m[i] = shadow_m[i];
        cq.push_back(pack_active());
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        if (a[3] == 1'b0 && int'(a[2:0]) < NW) shadow_m[a[2:0]] = d[WW-1:0];
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        rd_exp_t x;
        x.name = nm;
        x.exp  = e;
        rd_q.push_back(x);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        rd_req         = 1'b1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        rd_req         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        logic [NW*WW-1:0] w;
        if (reset_n) begin
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_scoreboard: read with no expectation, got %0h", bus.readdata);
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, 128'(bus.readdata), 128'(e.exp));
                end
            end
            if (commit_done) begin
                if (cq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got commit_done=1 expected no commit");
                end else begin
                    w = cq.pop_front();
                    check("commit_weights", 128'(weights_out), 128'(w));
                end
            end
        end
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_weights_out", 128'(weights_out), 128'd0);
        check("rst_weights_valid", 128'(weights_valid), 128'd0);
        check("rst_commit_done", 128'(commit_done), 128'd0);
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
        check("rst_irq", 128'(irq), 128'd0);
`endif
        @(posedge clk);
        #1 reset_n = 1'b1;

        rd(A_STATUS, 32'h0000_0000, "rst_status");
        rd(A_CTRL, 32'h0000_0000, "rst_ctrl");
        rd(4'd3, 32'h0000_0000, "rst_shadow3");

        // basic commit, one-edge latency
        wr(4'd3, 32'h0001_FFFF);
        rd(4'd3, 32'hFFFF_FFFF, "shadow3_sext");
        wr(A_CTRL, 32'h1);
        model_copy();
        check("basic_no_early_done", 128'(commit_done), 128'd0);
        check("basic_no_early_copy", 128'(weights_out[3*WW +: WW]), 128'd0);
        tick();
        check("basic_done_pulse", 128'(commit_done), 128'd1);
        check("basic_slice3", 128'(weights_out[3*WW +: WW]), 128'h1FFFF);
        check("basic_valid", 128'(weights_valid), 128'd1);
        tick();
        check("basic_done_single", 128'(commit_done), 128'd0);
        wr(A_CTRL, 32'h2);
        rd(4'd3, 32'hFFFF_FFFF, "active3_sext");
        rd(A_CTRL, 32'h0000_0002, "ctrl_rd_active");
        rd(A_STATUS, 32'h0000_0104, "status_after_basic");
        wr(A_CTRL, 32'h0);

        // busy hold
        layer_busy = 1'b1;
        wr(4'd0, 32'd5);
        wr(A_CTRL, 32'h1);
        model_copy();
        snap = weights_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("busy_hold_stable", 128'(weights_out), 128'(snap));
        end
        rd(A_STATUS, 32'h0000_0105, "busy_status_pending");
        layer_busy = 1'b0;
        tick();
        rd(A_STATUS, 32'h0000_0204, "busy_status_after");

        // shadow write on the copy edge
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        layer_busy = 1'b0;
        model_copy();
        wr(4'd1, 32'd7);
        rd(4'd1, 32'd7, "same_edge_shadow1");
        wr(A_CTRL, 32'h2);
        rd(4'd1, 32'd0, "same_edge_active1_old");
        wr(A_CTRL, 32'h3);
        model_copy();
        tick();
        rd(4'd1, 32'd7, "second_commit_active1");
        rd(A_STATUS, 32'h0000_0404, "status_count4");

        // abort
        wr(A_CTRL, 32'h0);
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h5);
        rd(A_STATUS, 32'h0000_0404, "abort_wins_idle");
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, 32'h0000_0405, "pending_under_busy");
        wr(A_CTRL, 32'h4);
        rd(A_STATUS, 32'h0000_0404, "abort_clears");
        layer_busy = 1'b0;
        repeat (3) tick();
        rd(A_STATUS, 32'h0000_0404, "abort_no_copy");

        // COMMIT on the copy edge queues a second copy
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        layer_busy = 1'b0;
        model_copy();
        model_copy();
        wr(A_CTRL, 32'h1);
        tick();
        rd(A_STATUS, 32'h0000_0604, "commit_on_copy_twice");

        // ABORT on the copy edge: copy still happens
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        layer_busy = 1'b0;
        model_copy();
        wr(A_CTRL, 32'h4);
        rd(A_STATUS, 32'h0000_0704, "abort_on_copy");

        // out-of-range indices
        wr(4'd6, 32'h0000_1234);
        wr(4'd7, 32'h0000_0055);
        rd(4'd6, 32'd0, "oor_rd6");
        rd(4'd7, 32'd0, "oor_rd7");
        wr(A_CTRL, 32'h2);
        rd(4'd6, 32'd0, "oor_rd6_active");
        wr(A_CTRL, 32'h1);
        model_copy();
        tick();
        rd(A_STATUS, 32'h0000_0804, "status_count8");

        // commit counter wrap
        for (int i = 0; i < 247; i++) begin
            wr(A_CTRL, 32'h1);
            model_copy();
            tick();
        end
        rd(A_STATUS, 32'h0000_FF04, "count_255");
        wr(A_CTRL, 32'h1);
        model_copy();
        tick();
        rd(A_STATUS, 32'h0000_0004, "count_wrap");

        // reset while pending
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        reset_n = 1'b0;
        #2;
        check("midrst_weights_out", 128'(weights_out), 128'd0);
        check("midrst_valid", 128'(weights_valid), 128'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear();
        layer_busy = 1'b0;
        repeat (3) tick();
        rd(A_STATUS, 32'h0000_0000, "midrst_status");
        wr(A_CTRL, 32'h2);
        rd(4'd3, 32'd0, "midrst_active3");
        wr(A_CTRL, 32'h0);

        wr(4'd2, 32'h0001_0000);
        rd(4'd2, 32'hFFFF_0000, "shadow2_neg");
`ifdef FFNN_WEIGHT_BANK_IRQ_EN
        wr(A_IRQEN, 32'h1);
        rd(A_IRQEN, 32'h1, "irqen_rd");
        check("irq_idle", 128'(irq), 128'd0);
        wr(A_CTRL, 32'h1);
        model_copy();
        check("irq_before_copy", 128'(irq), 128'd0);
        tick();
        check("irq_after_copy", 128'(irq), 128'd1);
        rd(A_STATUS, 32'h0000_0106, "status_irq_flag");
        wr(A_STATUS, 32'h2);
        check("irq_cleared", 128'(irq), 128'd0);
        rd(A_STATUS, 32'h0000_0104, "status_flag_cleared");
        layer_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        layer_busy = 1'b0;
        model_copy();
        wr(A_STATUS, 32'h2);
        check("irq_set_wins", 128'(irq), 128'd1);
        rd(A_STATUS, 32'h0000_0206, "status_set_wins");
`else
        wr(A_IRQEN, 32'h1);
        rd(A_IRQEN, 32'h0, "irqen_rd_zero");
        wr(A_CTRL, 32'h1);
        model_copy();
        tick();
        rd(A_STATUS, 32'h0000_0104, "status_no_irq");
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, 32'h0000_0104, "status_wr_ignored");
`endif

        repeat (2) tick();
        check("rd_queue_drained", 128'(rd_q.size()), 128'd0);
        check("commit_queue_drained", 128'(cq.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
